// File: rtl/dct_pkg.sv
// Shared defaults and types for the DCT multiply-accumulate lane.
package dct_pkg;

  localparam int DCT_DWIDTH = 8;
  localparam int DCT_CWIDTH = 8;
  localparam int DCT_NTAPS  = 8;
  localparam int DCT_RWIDTH = 20;

  typedef enum logic {
    IDLE,
    ACCUM
  } mac_state_t;

  // The tap counter must be able to hold the value NTAPS itself.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/dct_mult_stage.sv
// Sample/coefficient capture and registered signed multiply.
module dct_mult_stage #(
  parameter int DWIDTH = 8,
  parameter int CWIDTH = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              ena,
  input  logic        [DWIDTH-1:0]          din,
  input  logic        [CWIDTH-1:0]          coef,
  input  logic                              v_in,
  input  logic                              f_in,
  output logic signed [DWIDTH+CWIDTH-1:0]   mult_res,
  output logic                              v_out,
  output logic                              f_out,
  output logic                              v_mid
);

  localparam int PW = DWIDTH + CWIDTH;

  logic [DWIDTH-1:0] din_r;
  logic [CWIDTH-1:0] coef_r;
  logic              f1;
  logic signed [PW-1:0] din_x;
  logic signed [PW-1:0] coef_x;

  assign din_x  = $signed({{CWIDTH{din_r[DWIDTH-1]}}, din_r});
  assign coef_x = $signed({{DWIDTH{coef_r[CWIDTH-1]}}, coef_r});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      din_r    <= '0;
      coef_r   <= '0;
      v_mid    <= 1'b0;
      f1       <= 1'b0;
      mult_res <= '0;
      v_out    <= 1'b0;
      f_out    <= 1'b0;
    end else if (ena) begin
      din_r    <= din;
      coef_r   <= coef;
      v_mid    <= v_in;
      f1       <= f_in;
      mult_res <= din_x * coef_x;
      v_out    <= v_mid;
      f_out    <= f1;
    end
  end

endmodule

// File: rtl/dct_mac_pipe.sv
// Block-framed signed MAC for one DCT coefficient lane.
module dct_mac_pipe
  import dct_pkg::*;
#(
  parameter int DWIDTH = DCT_DWIDTH,
  parameter int CWIDTH = DCT_CWIDTH,
  parameter int NTAPS  = DCT_NTAPS,
  parameter int RWIDTH = DCT_RWIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic                     start,
  input  logic                     din_valid,
  input  logic        [DWIDTH-1:0] din,
  input  logic        [CWIDTH-1:0] coef,
  output logic signed [RWIDTH-1:0] result,
  output logic                     result_valid,
  output logic                     busy
);

  localparam int PW = DWIDTH + CWIDTH;
  localparam int CW = cnt_width(NTAPS);
  localparam logic [CW-1:0] NT = CW'(NTAPS);

  if (NTAPS < 1) begin : g_ntaps_chk
    $error("dct_mac_pipe: NTAPS must be >= 1");
  end
  if (RWIDTH < PW + $clog2(NTAPS)) begin : g_rw_chk
    $error("dct_mac_pipe: RWIDTH too narrow for NTAPS products");
  end

  mac_state_t state;
  logic [CW-1:0] tcnt;
  logic [CW-1:0] tcnt_nxt;
  logic          accept;

  assign accept   = din_valid & (start | (state == ACCUM));
  assign tcnt_nxt = start ? CW'(1) : tcnt + CW'(1);

  // Framing counts accepted samples so a block closes at S1 time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      tcnt  <= '0;
    end else if (ena && accept) begin
      if (tcnt_nxt == NT) begin
        state <= IDLE;
        tcnt  <= '0;
      end else begin
        state <= ACCUM;
        tcnt  <= tcnt_nxt;
      end
    end
  end

  logic signed [PW-1:0] mult_res;
  logic v1;
  logic v2;
  logic f2;

  dct_mult_stage #(
    .DWIDTH (DWIDTH),
    .CWIDTH (CWIDTH)
  ) u_mult (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .din      (din),
    .coef     (coef),
    .v_in     (accept),
    .f_in     (start),
    .mult_res (mult_res),
    .v_out    (v2),
    .f_out    (f2),
    .v_mid    (v1)
  );

  logic signed [RWIDTH-1:0] prod;
  logic signed [RWIDTH-1:0] acc;
  logic signed [RWIDTH-1:0] acc_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          done;

  assign prod    = RWIDTH'(mult_res);
  assign acc_nxt = f2 ? prod : acc + prod;
  assign cnt_nxt = f2 ? CW'(1) : cnt + CW'(1);
  assign done    = v2 & (cnt_nxt == NT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc          <= '0;
      cnt          <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else if (ena) begin
      result_valid <= done;
      if (v2) begin
        acc <= acc_nxt;
        cnt <= done ? '0 : cnt_nxt;
      end
      if (done) result <= acc_nxt;
    end else begin
      result_valid <= 1'b0;
    end
  end

  assign busy = (state == ACCUM) | v1 | v2;

endmodule
